sound_arbiter: RTL and testbench
================================

// Module: sound_arbiter
// PURPOSE
//  Shares the single Sound/buzzer engine between two requesters: free-play key hits (FP) and the
//  song player (SG, autoplay/learn). Grants one note at a time, drives the engine's start/stop,
//  enforces a silent inter-note gap, lets FP preempt SG, and recovers from a stalled engine.
//  Sits between the Hit/song front ends and Sound; owner output feeds Light.
// PARAMETERS
//  OCT_W        2        octave field width
//  NOTE_W       3        note field width
//  LEN_W        3        length field width
//  GAP_CYCLES   100000   silent cycles after each note (0 = no gap)
//  TIMEOUT      200000000 max cycles in PLAY before forced stop (>=2)
//  PREEMPT      1        1: FP request aborts a playing SG note
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-high
//  en           in   1      block enable; low forces IDLE
//  fp_req       in   1      FP note request, held until fp_ack
//  fp_oct/note/len in OCT_W/NOTE_W/LEN_W  FP payload, valid with fp_req
//  fp_ack       out  1      1-cycle pulse: FP payload accepted
//  fp_done      out  1      1-cycle pulse: FP note finished normally
//  sg_req       in   1      SG note request, held until sg_ack
//  sg_oct/note/len in OCT_W/NOTE_W/LEN_W  SG payload
//  sg_ack       out  1      1-cycle pulse: SG payload accepted
//  sg_done      out  1      1-cycle pulse: SG note finished normally
//  sg_abort     out  1      1-cycle pulse: SG note cut by preempt/en drop
//  snd_start    out  1      1-cycle pulse to engine
//  snd_stop     out  1      1-cycle pulse: engine must silence immediately
//  snd_oct/note/len out OCT_W/NOTE_W/LEN_W  latched payload, stable from START to end of PLAY
//  snd_over     in   1      engine: current note complete (pulse or level, sampled in PLAY only)
//  owner        out  2      0 none, 1 FP, 2 SG (none during GAP/IDLE)
//  timeout      out  1      1-cycle pulse: forced stop after TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, payload regs 0, counters 0. All outputs registered.
//  States IDLE, START, PLAY, STOP, GAP.
//  IDLE: if en & (fp_req|sg_req): FP wins ties (fixed priority); latch winner payload, -> START.
//  START (1 cycle): snd_start=1, winner ack=1, owner=winner, clear timer, -> PLAY.
//   Latency: req sampled at edge n -> ack+snd_start high in cycle n+1.
//   Requester must drop req the cycle after ack; a req dropped before ack is withdrawn silently.
//  PLAY: timer increments each cycle. Priority of exits (highest first):
//   1 !en: snd_stop=1, sg_abort=1 if owner SG, no done, -> IDLE.
//   2 snd_over: owner done pulse, -> GAP (IDLE if GAP_CYCLES==0).
//   3 timer==TIMEOUT-1: snd_stop=1, timeout=1, no done, -> GAP.
//   4 PREEMPT & owner==SG & fp_req: snd_stop=1, sg_abort=1, latch FP payload, -> STOP.
//  STOP (1 cycle): -> START (FP start follows stop by exactly one cycle, no gap).
//  GAP: owner=0; count GAP_CYCLES then -> IDLE; snd_over ignored; !en -> IDLE immediately.
//  snd_over outside PLAY is ignored. en low in any state -> IDLE next cycle; no acks issued.
//  SG req waits indefinitely while FP keeps requesting (no fairness; by design).
//  Reset mid-note: all outputs 0 at once; engine is stopped by its own reset.
//  Counter widths = $clog2(max(GAP_CYCLES,TIMEOUT)+1); no wrap in valid ranges.
// TESTING (GAP_CYCLES=4, TIMEOUT=20 in bench)
//  1 fp_req with oct=1,note=5,len=3 in IDLE -> fp_ack+snd_start next cycle, snd_note=5, owner=1.
//  2 fp_req & sg_req same cycle -> fp_ack only; after FP snd_over: fp_done, 4 gap cycles, then sg_ack.
//  3 SG playing, fp_req -> snd_stop+sg_abort, next cycle STOP, then fp_ack+snd_start; no sg_done.
//  4 SG playing, snd_over & fp_req same cycle -> sg_done, GAP, then fp_ack (no abort).
//  5 no snd_over for 20 cycles in PLAY -> snd_stop+timeout on 20th cycle, then GAP, no done.
//  6 en low during PLAY -> snd_stop one cycle, IDLE, owner=0; rst mid-GAP -> all outputs 0.

Source files
------------

// File: rtl/sound_arbiter.sv
// Arbitrates the shared Sound engine between free-play (FP) and song (SG) requesters:
// one note at a time, silent gap after each note, FP preempts SG, stalled-engine timeout.
module sound_arbiter #(
   parameter int OCT_W      = 2,
   parameter int NOTE_W     = 3,
   parameter int LEN_W      = 3,
   parameter int GAP_CYCLES = 100000,
   parameter int TIMEOUT    = 200000000,
   parameter int PREEMPT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fp_req,
   input  logic [OCT_W-1:0]  fp_oct,
   input  logic [NOTE_W-1:0] fp_note,
   input  logic [LEN_W-1:0]  fp_len,
   output logic              fp_ack,
   output logic              fp_done,
   input  logic              sg_req,
   input  logic [OCT_W-1:0]  sg_oct,
   input  logic [NOTE_W-1:0] sg_note,
   input  logic [LEN_W-1:0]  sg_len,
   output logic              sg_ack,
   output logic              sg_done,
   output logic              sg_abort,
   output logic              snd_start,
   output logic              snd_stop,
   output logic [OCT_W-1:0]  snd_oct,
   output logic [NOTE_W-1:0] snd_note,
   output logic [LEN_W-1:0]  snd_len,
   input  logic              snd_over,
   output logic [1:0]        owner,
   output logic              timeout,
   output logic [2:0]        dbg_state
);

   localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam int PAY_W   = OCT_W + NOTE_W + LEN_W;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_FP   = 2'd1;
   localparam logic [1:0] OWN_SG   = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_PLAY, S_STOP, S_GAP} state_t;

   state_t             r_state, w_state_nxt, w_quiet;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [1:0]         r_owner, w_owner_nxt;
   logic [PAY_W-1:0]   r_pay, w_pay_nxt;
   logic [PAY_W-1:0]   w_fp_pay, w_sg_pay;
   logic r_fp_ack, r_fp_done, r_sg_ack, r_sg_done, r_sg_abort, r_start, r_stop, r_timeout;
   logic w_fp_ack, w_fp_done, w_sg_ack, w_sg_done, w_sg_abort, w_start, w_stop, w_timeout;

   assign w_fp_pay = {fp_oct, fp_note, fp_len};
   assign w_sg_pay = {sg_oct, sg_note, sg_len};
   // A finished note always leaves through the quiet gap unless the gap is disabled.
   assign w_quiet  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_owner_nxt = r_owner;
      w_pay_nxt   = r_pay;
      w_fp_ack    = 1'b0;
      w_fp_done   = 1'b0;
      w_sg_ack    = 1'b0;
      w_sg_done   = 1'b0;
      w_sg_abort  = 1'b0;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_owner_nxt = OWN_NONE;
            w_cnt_nxt   = '0;
            if (en && fp_req) begin
               w_state_nxt = S_START;
               w_owner_nxt = OWN_FP;
               w_pay_nxt   = w_fp_pay;
               w_fp_ack    = 1'b1;
               w_start     = 1'b1;
            end else if (en && sg_req) begin
               w_state_nxt = S_START;
               w_owner_nxt = OWN_SG;
               w_pay_nxt   = w_sg_pay;
               w_sg_ack    = 1'b1;
               w_start     = 1'b1;
            end
         end
         S_START: begin
            w_cnt_nxt = '0;
            if (!en) begin
               w_state_nxt = S_IDLE;
               w_owner_nxt = OWN_NONE;
               w_stop      = 1'b1;
               w_sg_abort  = (r_owner == OWN_SG);
            end else begin
               w_state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            if (!en) begin
               w_state_nxt = S_IDLE;
               w_owner_nxt = OWN_NONE;
               w_stop      = 1'b1;
               w_sg_abort  = (r_owner == OWN_SG);
            end else if (snd_over) begin
               w_state_nxt = w_quiet;
               w_owner_nxt = OWN_NONE;
               w_cnt_nxt   = '0;
               w_fp_done   = (r_owner == OWN_FP);
               w_sg_done   = (r_owner == OWN_SG);
            end else if (r_cnt == TO_LAST) begin
               w_state_nxt = w_quiet;
               w_owner_nxt = OWN_NONE;
               w_cnt_nxt   = '0;
               w_stop      = 1'b1;
               w_timeout   = 1'b1;
            end else if ((PREEMPT != 0) && (r_owner == OWN_SG) && fp_req) begin
               w_state_nxt = S_STOP;
               w_owner_nxt = OWN_NONE;
               w_pay_nxt   = w_fp_pay;
               w_stop      = 1'b1;
               w_sg_abort  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            // The preempting FP payload was latched on the way in; start it with no gap.
            if (!en) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_START;
               w_owner_nxt = OWN_FP;
               w_cnt_nxt   = '0;
               w_fp_ack    = 1'b1;
               w_start     = 1'b1;
            end
         end
         S_GAP: begin
            w_owner_nxt = OWN_NONE;
            if (!en || r_cnt == GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = OWN_NONE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_owner    <= OWN_NONE;
         r_pay      <= '0;
         r_fp_ack   <= 1'b0;
         r_fp_done  <= 1'b0;
         r_sg_ack   <= 1'b0;
         r_sg_done  <= 1'b0;
         r_sg_abort <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_owner    <= w_owner_nxt;
         r_pay      <= w_pay_nxt;
         r_fp_ack   <= w_fp_ack;
         r_fp_done  <= w_fp_done;
         r_sg_ack   <= w_sg_ack;
         r_sg_done  <= w_sg_done;
         r_sg_abort <= w_sg_abort;
         r_start    <= w_start;
         r_stop     <= w_stop;
         r_timeout  <= w_timeout;
      end
   end

   assign fp_ack    = r_fp_ack;
   assign fp_done   = r_fp_done;
   assign sg_ack    = r_sg_ack;
   assign sg_done   = r_sg_done;
   assign sg_abort  = r_sg_abort;
   assign snd_start = r_start;
   assign snd_stop  = r_stop;
   assign timeout   = r_timeout;
   assign owner     = r_owner;
   assign {snd_oct, snd_note, snd_len} = r_pay;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter: directed scenarios then randomized requesters/engine,
// every cycle scored against a transaction-level reference model.
module tb_sound_arbiter;

   localparam int OCT_W = 2, NOTE_W = 3, LEN_W = 3;
   localparam int GAP = 4, TO = 20;
   localparam int VW = 18;
   localparam int B_FP_ACK = 17, B_SG_ACK = 15;
   localparam int P_IDLE = 0, P_START = 1, P_PLAY = 2, P_STOP = 3, P_GAP = 4;

   logic clk = 1'b0;
   logic rst, en, fp_req, sg_req, snd_over;
   logic [OCT_W-1:0]  fp_oct, sg_oct, snd_oct;
   logic [NOTE_W-1:0] fp_note, sg_note, snd_note;
   logic [LEN_W-1:0]  fp_len, sg_len, snd_len;
   logic fp_ack, fp_done, sg_ack, sg_done, sg_abort, snd_start, snd_stop, timeout;
   logic [1:0] owner;
   logic [2:0] dbg_state;

   sound_arbiter #(.OCT_W(OCT_W), .NOTE_W(NOTE_W), .LEN_W(LEN_W),
                   .GAP_CYCLES(GAP), .TIMEOUT(TO), .PREEMPT(1)) dut (
      .clk(clk), .rst(rst), .en(en),
      .fp_req(fp_req), .fp_oct(fp_oct), .fp_note(fp_note), .fp_len(fp_len),
      .fp_ack(fp_ack), .fp_done(fp_done),
      .sg_req(sg_req), .sg_oct(sg_oct), .sg_note(sg_note), .sg_len(sg_len),
      .sg_ack(sg_ack), .sg_done(sg_done), .sg_abort(sg_abort),
      .snd_start(snd_start), .snd_stop(snd_stop),
      .snd_oct(snd_oct), .snd_note(snd_note), .snd_len(snd_len),
      .snd_over(snd_over), .owner(owner), .timeout(timeout), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   int n_checks = 0;
   int n_fail   = 0;
   logic [VW-1:0] exp_q[$];
   logic [VW-1:0] last_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] dut_vec();
      return {fp_ack, fp_done, sg_ack, sg_done, sg_abort, snd_start, snd_stop, timeout,
              owner, snd_oct, snd_note, snd_len};
   endfunction

   // reference model: who is sounding, how long it has played, how much quiet is left
   int m_phase;
   int m_age;
   int m_quiet;
   logic [1:0]        m_owner;
   logic [OCT_W-1:0]  m_oct;
   logic [NOTE_W-1:0] m_note;
   logic [LEN_W-1:0]  m_len;

   task automatic model_reset();
      m_phase = P_IDLE; m_age = 0; m_quiet = 0; m_owner = 2'd0;
      m_oct = '0; m_note = '0; m_len = '0;
   endtask

   task automatic go_quiet();
      m_owner = 2'd0;
      if (GAP == 0) m_phase = P_IDLE;
      else begin m_phase = P_GAP; m_quiet = GAP; end
   endtask

   // Predicts the outputs seen in the cycle after the coming clock edge.
   task automatic model_step();
      logic fa = 1'b0, fd = 1'b0, sa = 1'b0, sd = 1'b0;
      logic ab = 1'b0, st = 1'b0, sp = 1'b0, tmo = 1'b0;
      case (m_phase)
         P_IDLE: if (en && (fp_req || sg_req)) begin
            if (fp_req) begin
               m_owner = 2'd1; fa = 1'b1; m_oct = fp_oct; m_note = fp_note; m_len = fp_len;
            end else begin
               m_owner = 2'd2; sa = 1'b1; m_oct = sg_oct; m_note = sg_note; m_len = sg_len;
            end
            st = 1'b1; m_phase = P_START;
         end
         P_START: if (!en) begin
            sp = 1'b1; ab = (m_owner == 2'd2); m_owner = 2'd0; m_phase = P_IDLE;
         end else begin
            m_phase = P_PLAY; m_age = 0;
         end
         P_PLAY: if (!en) begin
            sp = 1'b1; ab = (m_owner == 2'd2); m_owner = 2'd0; m_phase = P_IDLE;
         end else if (snd_over) begin
            fd = (m_owner == 2'd1); sd = (m_owner == 2'd2); go_quiet();
         end else if (m_age == TO - 1) begin
            sp = 1'b1; tmo = 1'b1; go_quiet();
         end else if (m_owner == 2'd2 && fp_req) begin
            sp = 1'b1; ab = 1'b1; m_owner = 2'd0; m_phase = P_STOP;
            m_oct = fp_oct; m_note = fp_note; m_len = fp_len;
         end else begin
            m_age++;
         end
         P_STOP: if (!en) m_phase = P_IDLE;
         else begin
            m_phase = P_START; m_owner = 2'd1; fa = 1'b1; st = 1'b1;
         end
         default: if (!en) m_phase = P_IDLE;
         else begin
            m_quiet--;
            if (m_quiet == 0) m_phase = P_IDLE;
         end
      endcase
      exp_q.push_back({fa, fd, sa, sd, ab, st, sp, tmo, m_owner, m_oct, m_note, m_len});
   endtask

   // driver tasks
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      last_exp = exp_q.pop_front();
      check("outs", 32'(dut_vec()), 32'(last_exp));
   endtask

   task automatic settle();
      int n = 0;
      while (m_phase != P_IDLE && n < 50) begin tick(); n++; end
      if (m_phase != P_IDLE) check("settle_bound", m_phase, P_IDLE);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1 check("rst_async", 32'(dut_vec()), 32'd0);
      model_reset();
      exp_q.delete();
      fp_req = 1'b0; sg_req = 1'b0; snd_over = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_fp(input int o, input int n, input int l);
      fp_oct = OCT_W'(o); fp_note = NOTE_W'(n); fp_len = LEN_W'(l); fp_req = 1'b1;
   endtask

   task automatic set_sg(input int o, input int n, input int l);
      sg_oct = OCT_W'(o); sg_note = NOTE_W'(n); sg_len = LEN_W'(l); sg_req = 1'b1;
   endtask

   initial begin
      int p_over;
      rst = 1'b1; en = 1'b0; fp_req = 1'b0; sg_req = 1'b0; snd_over = 1'b0;
      fp_oct = '0; fp_note = '0; fp_len = '0; sg_oct = '0; sg_note = '0; sg_len = '0;
      last_exp = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_outs", 32'(dut_vec()), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0; en = 1'b1;

      // 1: simple FP note
      set_fp(1, 5, 3);
      tick();
      check("t1_fp_ack", fp_ack, 1); check("t1_start", snd_start, 1);
      check("t1_note", snd_note, 5); check("t1_oct", snd_oct, 1);
      check("t1_len", snd_len, 3); check("t1_owner", owner, 1);
      fp_req = 1'b0;
      tick(); tick();
      snd_over = 1'b1; tick(); snd_over = 1'b0;
      check("t1_done", fp_done, 1); check("t1_owner_gap", owner, 0);
      settle();

      // 2: tie goes to FP, SG acked only after the gap
      set_fp(2, 1, 4); set_sg(3, 6, 2);
      tick();
      check("t2_fp_ack", fp_ack, 1); check("t2_no_sg_ack", sg_ack, 0);
      fp_req = 1'b0;
      tick();
      snd_over = 1'b1; tick(); snd_over = 1'b0;
      check("t2_fp_done", fp_done, 1);
      repeat (4) tick();
      check("t2_sg_wait", sg_ack, 0);
      tick();
      check("t2_sg_ack", sg_ack, 1); check("t2_owner_sg", owner, 2);
      sg_req = 1'b0;

      // 3: FP preempts the playing SG note
      set_fp(2, 3, 6);
      tick(); tick();
      check("t3_stop", snd_stop, 1); check("t3_abort", sg_abort, 1); check("t3_no_done", sg_done, 0);
      tick();
      check("t3_fp_ack", fp_ack, 1); check("t3_start", snd_start, 1);
      check("t3_owner", owner, 1); check("t3_note", snd_note, 3);
      fp_req = 1'b0;
      tick();
      snd_over = 1'b1; tick(); snd_over = 1'b0;
      settle();

      // 4: SG finishes in the same cycle FP asks: done, not abort
      set_sg(0, 7, 1);
      tick();
      check("t4_sg_ack", sg_ack, 1);
      sg_req = 1'b0;
      tick();
      snd_over = 1'b1; set_fp(1, 2, 5);
      tick(); snd_over = 1'b0;
      check("t4_sg_done", sg_done, 1); check("t4_no_abort", sg_abort, 0); check("t4_no_stop", snd_stop, 0);
      repeat (4) tick();
      check("t4_fp_wait", fp_ack, 0);
      tick();
      check("t4_fp_ack", fp_ack, 1);
      fp_req = 1'b0;

      // 5: engine never reports over -> timeout after TO play cycles
      repeat (TO) tick();
      check("t5_no_early", timeout, 0);
      tick();
      check("t5_stop", snd_stop, 1); check("t5_timeout", timeout, 1); check("t5_no_done", fp_done, 0);
      settle();

      // 6: en drop during play, then reset in the gap
      set_sg(1, 4, 2);
      tick(); sg_req = 1'b0;
      tick();
      en = 1'b0; tick();
      check("t6_stop", snd_stop, 1); check("t6_abort", sg_abort, 1); check("t6_owner", owner, 0);
      en = 1'b1; tick();
      set_fp(3, 3, 3);
      tick(); fp_req = 1'b0;
      tick();
      snd_over = 1'b1; tick(); snd_over = 1'b0;
      tick();
      async_reset();

      // randomized requesters, engine and enable
      fp_req = 1'b0; sg_req = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         p_over = (i < 1000) ? 30 : (i < 2000) ? 3 : 15;
         if (fp_req && last_exp[B_FP_ACK]) fp_req = 1'b0;
         else if (!fp_req && $urandom_range(0, 99) < 8)
            set_fp($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
         if (sg_req && last_exp[B_SG_ACK]) sg_req = 1'b0;
         else if (sg_req && $urandom_range(0, 99) < 2) sg_req = 1'b0;
         else if (!sg_req && $urandom_range(0, 99) < 20)
            set_sg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
         snd_over = ($urandom_range(0, 99) < p_over);
         en = ($urandom_range(0, 99) < 97);
         tick();
         if (i == 1500) async_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
